// File: rtl/sd_data_receive_fsm_pkg.sv
// Shared data-path definitions for the SD host receive side.
// State codes are common to every data-line block.
package sd_data_receive_fsm_pkg;

  typedef enum logic [3:0] {
    DATA_STATE_STOP            = 4'b0000,
    DATA_STATE_WAIT_RECEIVE    = 4'b0010,
    DATA_STATE_RECEIVE         = 4'b0011,
    DATA_STATE_RECEIVE_CRC     = 4'b0100,
    DATA_STATE_RECEIVE_END_BIT = 4'b0101
  } data_state_e;

  localparam int BEAT_W = 14;
  localparam logic [3:0] CRC_LAST = 4'hF;

  // Index of the final data beat: bytes*8 on 1-bit, bytes*2 on 4-bit.
  function automatic logic [BEAT_W-1:0] last_beat(
    input logic [11:0] len,
    input logic        wide
  );
    logic [14:0] beats;
    beats = wide ? {2'b00, len, 1'b0} : {len, 3'b000};
    return BEAT_W'(beats - 15'd1);
  endfunction

endpackage

// File: rtl/sd_data_timeout_cnt.sv
// Read data timeout: loadable down-counter with hold.
// last_o flags that the current decrement reaches zero.
module sd_data_timeout_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins, then load, then count down; no dec means hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q <= W'(1));

endmodule

// File: rtl/sd_data_receive_fsm.sv
// SD host receive data-line controller.
// Start bit, data beats, CRC, end bit; block count and timeout.
module sd_data_receive_fsm
  import sd_data_receive_fsm_pkg::*;
#(
  parameter int TIMEOUT_W = 32
) (
  input  logic                 in_sd_clk,
  input  logic                 hrst_n,
  input  logic                 in_soft_reset,
  input  logic                 in_read_start,
  input  logic                 in_stop_transfer,
  input  logic                 in_data_width,
  input  logic [3:0]           in_serial_data,
  input  logic [11:0]          in_block_len,
  input  logic [15:0]          in_block_number,
  input  logic [TIMEOUT_W-1:0] in_timeout_value,
  input  logic                 in_rx_fifo_full,
  input  logic                 in_receive_data_crc_error,
  output logic [3:0]           out_current_state,
  output logic [13:0]          out_has_receive_bit,
  output logic [15:0]          out_blocks_received,
  output logic                 out_clk_stop_req,
  output logic                 out_block_done,
  output logic                 out_transfer_done,
  output logic                 out_data_timeout_error,
  output logic                 out_data_crc_error,
  output logic                 out_end_bit_error
);

  data_state_e       state_q, state_d;
  logic [BEAT_W-1:0] bit_q, bit_d;
  logic [15:0]       blk_q, blk_d;
  logic              bdone_q, bdone_d;
  logic              xdone_q, xdone_d;
  logic              tmo_q, tmo_d;
  logic              crc_q, crc_d;
  logic              ebit_q, ebit_d;
  logic              tmo_load, tmo_dec, tmo_last;
  logic              start_bit, end_ok, clk_stop;

  assign start_bit = in_data_width ? (in_serial_data == 4'h0)
                                   : ~in_serial_data[0];
  assign end_ok    = in_data_width ? (&in_serial_data)
                                   : in_serial_data[0];
  assign clk_stop  = in_rx_fifo_full
                  && state_q == DATA_STATE_WAIT_RECEIVE
                  && blk_q != 16'd0;

  sd_data_timeout_cnt #(.W(TIMEOUT_W)) u_tmo (
    .clk_i  (in_sd_clk),
    .rst_ni (hrst_n),
    .clr_i  (~in_soft_reset),
    .load_i (tmo_load),
    .val_i  (in_timeout_value),
    .dec_i  (tmo_dec),
    .last_o (tmo_last)
  );

  // Next state, counters and event pulses.
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    blk_d    = blk_q;
    bdone_d  = 1'b0;
    xdone_d  = 1'b0;
    tmo_d    = 1'b0;
    crc_d    = 1'b0;
    ebit_d   = 1'b0;
    tmo_load = 1'b0;
    tmo_dec  = 1'b0;
    if (in_stop_transfer && state_q != DATA_STATE_STOP) begin
      state_d = DATA_STATE_STOP;
      bit_d   = '0;
      xdone_d = 1'b1;
    end else begin
      unique case (state_q)
        DATA_STATE_STOP: begin
          if (in_read_start && !in_stop_transfer) begin
            state_d  = DATA_STATE_WAIT_RECEIVE;
            blk_d    = 16'd0;
            tmo_load = 1'b1;
          end
        end
        DATA_STATE_WAIT_RECEIVE: begin
          if (start_bit) begin
            state_d = DATA_STATE_RECEIVE;
            bit_d   = '0;
          end else if (!clk_stop) begin
            tmo_dec = 1'b1;
            if (tmo_last) begin
              tmo_d   = 1'b1;
              state_d = DATA_STATE_STOP;
            end
          end
        end
        DATA_STATE_RECEIVE: begin
          if (bit_q == last_beat(in_block_len, in_data_width)) begin
            state_d = DATA_STATE_RECEIVE_CRC;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BEAT_W'(1);
          end
        end
        DATA_STATE_RECEIVE_CRC: begin
          if (bit_q[3:0] == CRC_LAST) begin
            state_d = DATA_STATE_RECEIVE_END_BIT;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BEAT_W'(1);
          end
        end
        DATA_STATE_RECEIVE_END_BIT: begin
          bit_d = '0;
          if (!end_ok) begin
            ebit_d  = 1'b1;
            state_d = DATA_STATE_STOP;
          end else if (in_receive_data_crc_error) begin
            crc_d   = 1'b1;
            state_d = DATA_STATE_STOP;
          end else begin
            bdone_d = 1'b1;
            blk_d   = blk_q + 16'd1;
            if (in_block_number != 16'd0
                && blk_d == in_block_number) begin
              xdone_d = 1'b1;
              state_d = DATA_STATE_STOP;
            end else begin
              state_d  = DATA_STATE_WAIT_RECEIVE;
              tmo_load = 1'b1;
            end
          end
        end
        default: begin
          state_d = DATA_STATE_STOP;
          bit_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered pulses; soft reset is synchronous.
  always_ff @(posedge in_sd_clk or negedge hrst_n) begin
    if (!hrst_n) begin
      state_q <= DATA_STATE_STOP;
      bit_q   <= '0;
      blk_q   <= '0;
      bdone_q <= 1'b0;
      xdone_q <= 1'b0;
      tmo_q   <= 1'b0;
      crc_q   <= 1'b0;
      ebit_q  <= 1'b0;
    end else if (!in_soft_reset) begin
      state_q <= DATA_STATE_STOP;
      bit_q   <= '0;
      blk_q   <= '0;
      bdone_q <= 1'b0;
      xdone_q <= 1'b0;
      tmo_q   <= 1'b0;
      crc_q   <= 1'b0;
      ebit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      blk_q   <= blk_d;
      bdone_q <= bdone_d;
      xdone_q <= xdone_d;
      tmo_q   <= tmo_d;
      crc_q   <= crc_d;
      ebit_q  <= ebit_d;
    end
  end

  assign out_current_state      = state_q;
  assign out_has_receive_bit    = bit_q;
  assign out_blocks_received    = blk_q;
  assign out_clk_stop_req       = clk_stop;
  assign out_block_done         = bdone_q;
  assign out_transfer_done      = xdone_q;
  assign out_data_timeout_error = tmo_q;
  assign out_data_crc_error     = crc_q;
  assign out_end_bit_error      = ebit_q;

endmodule
